// File: rtl/seq_alu_exec.sv
// seq_alu_exec: execute-stage ALU driven by the 4-bit ALUSel code.
// Non-shift ops take one cycle. Shifts are iterative at one bit per cycle,
// unless FAST_SHIFT_EN is defined. With FAST_SHIFT_EN a barrel shifter
// handles shifts in a single cycle, and the SHIFT state and counter go away.
// valid/ready handshakes on input and output let the pipeline stall EX.
module seq_alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] SEL_ADD  = 4'b0000;
    localparam logic [3:0] SEL_SUB  = 4'b0001;
    localparam logic [3:0] SEL_OR   = 4'b0100;
    localparam logic [3:0] SEL_AND  = 4'b0101;
    localparam logic [3:0] SEL_XOR  = 4'b0111;
    localparam logic [3:0] SEL_SLT  = 4'b1101;
    localparam logic [3:0] SEL_SLTU = 4'b1111;
    localparam logic [3:0] SEL_SLL  = 4'b1001;
    localparam logic [3:0] SEL_SRL  = 4'b1000;
    localparam logic [3:0] SEL_SRA  = 4'b1010;
    localparam logic [3:0] SEL_PASS = 4'b0011;

`ifdef FAST_SHIFT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_DONE} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
    typedef enum logic [1:0] {SK_SLL, SK_SRL, SK_SRA} shkind_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_legal;
    logic             is_shift;

`ifndef FAST_SHIFT_EN
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    shkind_t          kind_q, kind_d;
    shkind_t          kind_in;
    logic [WIDTH-1:0] acc_step;
`endif

    assign shamt     = op_b[SHW-1:0];
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

    // Single-cycle datapath: decode ALUSel and compute the result from the live operands.
    always_comb begin
        alu_res   = '0;
        alu_legal = 1'b1;
        is_shift  = 1'b0;
        case (alu_sel)
            SEL_ADD:  alu_res = op_a + op_b;
            SEL_SUB:  alu_res = op_a - op_b;
            SEL_OR:   alu_res = op_a | op_b;
            SEL_AND:  alu_res = op_a & op_b;
            SEL_XOR:  alu_res = op_a ^ op_b;
            SEL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            SEL_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            SEL_PASS: alu_res = op_b;
`ifdef FAST_SHIFT_EN
            SEL_SLL: begin
                is_shift = 1'b1;
                alu_res  = op_a << shamt;
            end
            SEL_SRL: begin
                is_shift = 1'b1;
                alu_res  = op_a >> shamt;
            end
            SEL_SRA: begin
                is_shift = 1'b1;
                alu_res  = WIDTH'($signed(op_a) >>> shamt);
            end
`else
            // The iterative path only uses this value when shamt is zero, where every shift returns op_a.
            SEL_SLL, SEL_SRL, SEL_SRA: begin
                is_shift = 1'b1;
                alu_res  = op_a;
            end
`endif
            default:  alu_legal = 1'b0;
        endcase
    end

`ifndef FAST_SHIFT_EN
    // Shift-kind selection at accept, and the one-bit step applied to the accumulator.
    always_comb begin
        kind_in = SK_SRA;
        if (alu_sel == SEL_SLL) begin
            kind_in = SK_SLL;
        end else if (alu_sel == SEL_SRL) begin
            kind_in = SK_SRL;
        end
        case (kind_q)
            SK_SLL:  acc_step = {acc_q[WIDTH-2:0], 1'b0};
            SK_SRL:  acc_step = {1'b0, acc_q[WIDTH-1:1]};
            default: acc_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        endcase
    end
`endif

    // Next-state and result logic. Result, zero and illegal always update together.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
`ifndef FAST_SHIFT_EN
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        kind_d    = kind_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
`ifndef FAST_SHIFT_EN
                    if (is_shift && (shamt != '0)) begin
                        acc_d   = op_a;
                        cnt_d   = shamt;
                        kind_d  = kind_in;
                        state_d = ST_SHIFT;
                    end else
`endif
                    begin
                        result_d  = alu_res;
                        zero_d    = (alu_res == '0);
                        illegal_d = ~alu_legal;
                        state_d   = ST_DONE;
                    end
                end
            end
`ifndef FAST_SHIFT_EN
            ST_SHIFT: begin
                acc_d = acc_step;
                cnt_d = cnt_q - 1'b1;
                // The step taken with cnt at 1 is the last one, so it goes straight into result.
                if (cnt_q == SHW'(1)) begin
                    result_d  = acc_step;
                    zero_d    = (acc_step == '0);
                    illegal_d = 1'b0;
                    state_d   = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers. Reset aborts any op in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
`ifndef FAST_SHIFT_EN
            acc_q     <= '0;
            cnt_q     <= '0;
            kind_q    <= SK_SLL;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
`ifndef FAST_SHIFT_EN
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            kind_q    <= kind_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_alu_exec.sv
// Self-checking bench for seq_alu_exec. The bench compares DUT results against
// a behavioural model built from plain arithmetic operators and a wait-cycle rule.
module tb_seq_alu_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_sel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    // Values captured by do_op.
    logic [31:0] got_res;
    logic        got_zero;
    logic        got_ill;
    int          got_wait;
    logic        got_timeout;
    logic        got_ready_leak;

    seq_alu_exec #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_sel(alu_sel), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Reference ALU: the expected result for each ALUSel code.
    function automatic void ref_alu(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic ill);
        ill = 1'b0;
        case (sel)
            4'b0000: r = a + b;
            4'b0001: r = a - b;
            4'b0100: r = a | b;
            4'b0101: r = a & b;
            4'b0111: r = a ^ b;
            4'b1101: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1111: r = (a < b) ? 32'd1 : 32'd0;
            4'b1001: r = a << b[4:0];
            4'b1000: r = a >> b[4:0];
            4'b1010: r = 32'($signed(a) >>> b[4:0]);
            4'b0011: r = b;
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
    endfunction

    // Expected stall cycles between the accept edge and out_valid.
    function automatic int ref_wait(input logic [3:0] sel, input logic [31:0] b);
`ifdef FAST_SHIFT_EN
        return 0;
`else
        if (sel == 4'b1001 || sel == 4'b1000 || sel == 4'b1010) return int'(b[4:0]);
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op and wait (bounded) for out_valid. The result is left held in DONE.
    task automatic do_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        while (!in_ready && guard < 100) begin tick(); guard++; end
        alu_sel  = sel;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        // Scramble the inputs after accept. The design must ignore these changes.
        alu_sel  = 4'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        got_wait = 0;
        got_ready_leak = 1'b0;
        while (!out_valid && got_wait < 100) begin
            if (in_ready) got_ready_leak = 1'b1;
            tick();
            got_wait++;
        end
        got_timeout = !out_valid;
        got_res  = result;
        got_zero = zero;
        got_ill  = illegal;
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0 || zero !== 1'b1 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset: out_valid=%b in_ready=%b result=%h zero=%b illegal=%b, required 0 1 00000000 1 0",
                     out_valid, in_ready, result, zero, illegal);
        end
        $display("reset: out_valid=%b in_ready=%b result=%h zero=%b", out_valid, in_ready, result, zero);
    endtask

    task automatic test_add_sub();
        do_op(4'b0000, 32'd5, 32'd7);
        checks++;
        if (got_timeout || got_wait !== 0 || got_res !== 32'd12 || got_zero !== 1'b0) begin
            errors++;
            $display("FAIL add: result=%0d zero=%b wait=%0d, required 12 0 0", got_res, got_zero, got_wait);
        end
        $display("add 5+7: result=%0d zero=%b wait=%0d", got_res, got_zero, got_wait);
        release_op();
        do_op(4'b0001, 32'd7, 32'd7);
        checks++;
        if (got_timeout || got_wait !== 0 || got_res !== 32'd0 || got_zero !== 1'b1) begin
            errors++;
            $display("FAIL sub: result=%0d zero=%b wait=%0d, required 0 1 0", got_res, got_zero, got_wait);
        end
        $display("sub 7-7: result=%0d zero=%b", got_res, got_zero);
        release_op();
    endtask

    task automatic test_shift_sra();
        do_op(4'b1010, 32'h8000_0000, 32'd4);
        checks++;
        if (got_timeout || got_res !== 32'hF800_0000 || got_wait !== ref_wait(4'b1010, 32'd4) || got_ready_leak) begin
            errors++;
            $display("FAIL sra: result=%h wait=%0d ready_leak=%b, required f8000000 %0d 0",
                     got_res, got_wait, got_ready_leak, ref_wait(4'b1010, 32'd4));
        end
        $display("sra 80000000>>>4: result=%h wait=%0d", got_res, got_wait);
        release_op();
    endtask

    task automatic test_compare_illegal();
        do_op(4'b1101, 32'hFFFF_FFFF, 32'd1);
        checks++;
        if (got_res !== 32'd1 || got_ill !== 1'b0) begin
            errors++;
            $display("FAIL slt: result=%0d illegal=%b, required 1 0", got_res, got_ill);
        end
        $display("slt -1<1: result=%0d", got_res);
        release_op();
        do_op(4'b1111, 32'hFFFF_FFFF, 32'd1);
        checks++;
        if (got_res !== 32'd0 || got_zero !== 1'b1) begin
            errors++;
            $display("FAIL sltu: result=%0d zero=%b, required 0 1", got_res, got_zero);
        end
        $display("sltu ffffffff<1: result=%0d", got_res);
        release_op();
        do_op(4'b0010, 32'h1234_5678, 32'h9ABC_DEF0);
        checks++;
        if (got_res !== 32'd0 || got_ill !== 1'b1 || got_zero !== 1'b1) begin
            errors++;
            $display("FAIL illegal: result=%h illegal=%b zero=%b, required 0 1 1", got_res, got_ill, got_zero);
        end
        $display("sel 0010: result=%h illegal=%b", got_res, got_ill);
        release_op();
        // A legal op must clear the illegal flag again.
        do_op(4'b0011, 32'd0, 32'hCAFE_0000);
        checks++;
        if (got_res !== 32'hCAFE_0000 || got_ill !== 1'b0) begin
            errors++;
            $display("FAIL pass_b: result=%h illegal=%b, required cafe0000 0", got_res, got_ill);
        end
        $display("pass b: result=%h illegal=%b", got_res, got_ill);
        release_op();
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_r;
        logic        exp_i;
        ref_alu(4'b0111, 32'hA5A5_0F0F, 32'h0F0F_A5A5, exp_r, exp_i);
        do_op(4'b0111, 32'hA5A5_0F0F, 32'h0F0F_A5A5);
        // Offer a competing op while DONE is held. It must not be taken.
        alu_sel  = 4'b0000;
        op_a     = 32'd1;
        op_b     = 32'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp_r || illegal !== exp_i) begin
                errors++;
                $display("FAIL hold%0d: out_valid=%b in_ready=%b result=%h, required 1 0 %h", i, out_valid, in_ready, result, exp_r);
            end
            $display("hold %0d: result=%h out_valid=%b in_ready=%b", i, result, out_valid, in_ready);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== exp_r) begin
            errors++;
            $display("FAIL release: in_ready=%b out_valid=%b result=%h, required 1 0 %h", in_ready, out_valid, result, exp_r);
        end
        $display("release: in_ready=%b out_valid=%b", in_ready, out_valid);
    endtask

    task automatic test_reset_mid_shift();
        int saw_valid = 0;
        alu_sel  = 4'b1001;
        op_a     = 32'd1;
        op_b     = 32'd31;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (out_valid) saw_valid++;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifndef FAST_SHIFT_EN
        checks++;
        if (saw_valid !== 0) begin
            errors++;
            $display("FAIL shift_abort_valid: out_valid seen %0d cycles, required 0", saw_valid);
        end
`endif
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0 || zero !== 1'b1) begin
                errors++;
                $display("FAIL shift_abort%0d: out_valid=%b in_ready=%b result=%h zero=%b, required 0 1 0 1",
                         c, out_valid, in_ready, result, zero);
            end
            $display("post-abort %0d: out_valid=%b in_ready=%b result=%h", c, out_valid, in_ready, result);
            tick();
        end
    endtask

    task automatic test_random();
        logic [3:0]  sels [16];
        logic [3:0]  s;
        logic [31:0] a, b, exp_r;
        logic        exp_i;
        for (int i = 0; i < 16; i++) sels[i] = 4'(i);
        for (int n = 0; n < 60; n++) begin
            s = sels[$urandom_range(0, 15)];
            a = $urandom;
            b = $urandom;
            if (n % 7 == 0) b = 32'd0;
            ref_alu(s, a, b, exp_r, exp_i);
            do_op(s, a, b);
            checks++;
            if (got_timeout || got_res !== exp_r || got_ill !== exp_i || got_zero !== (exp_r == 32'd0)
                || got_wait !== ref_wait(s, b) || got_ready_leak) begin
                errors++;
                $display("FAIL rand%0d: sel=%b a=%h b=%h got res=%h ill=%b zero=%b wait=%0d, required res=%h ill=%b zero=%b wait=%0d",
                         n, s, a, b, got_res, got_ill, got_zero, got_wait, exp_r, exp_i, (exp_r == 32'd0), ref_wait(s, b));
            end
            $display("rand %0d: sel=%b a=%h b=%h res=%h wait=%0d", n, s, a, b, got_res, got_wait);
            for (int d = 0; d < int'($urandom_range(0, 2)); d++) tick();
            release_op();
        end
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_sel   = 4'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        #2;
        test_reset();
        test_add_sub();
        test_shift_sra();
        test_compare_illegal();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
